// File: rtl/char_rom_arbiter_if.sv
// rtl/char_rom_arbiter_if.sv - requester and char ROM signal bundle for char_rom_arbiter
// The arbiter connects through the slave modport; the renderers and ROM connect through the master modport.
interface char_rom_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              ack0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              ack1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] rom_rd_addr;
  logic [DATA_W-1:0] rom_rd_data;

  modport slave (
    input  req0, addr0, req1, addr1, rom_rd_data,
    output ack0, rvalid0, rdata0, ack1, rvalid1, rdata1, rom_rd_addr
  );

  modport master (
    output req0, addr0, req1, addr1, rom_rd_data,
    input  ack0, rvalid0, rdata0, ack1, rvalid1, rdata1, rom_rd_addr
  );
endinterface

// File: rtl/char_rom_arbiter.sv
// rtl/char_rom_arbiter.sv - round-robin sharing of the char ROM read port between two renderers
// One grant per clock; a {valid, idx} tag follows each read so the data returns to its issuer.
module char_rom_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  char_rom_arbiter_if.slave     bus
);

  logic              last;
  logic              tag_valid;
  logic              tag_idx;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              grant0;
  logic              grant1;
  logic              grant_any;
  logic [ADDR_W-1:0] rd_addr;

  // On a tie the requester that was not served last wins; nothing is granted in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (bus.req0 && bus.req1) begin
        grant0 = last;
        grant1 = ~last;
      end else begin
        grant0 = bus.req0;
        grant1 = bus.req1;
      end
    end
  end

  assign grant_any = grant0 | grant1;

  // Idle cycles keep presenting the previous address so the ROM address bus does not toggle.
  always_comb begin
    rd_addr = hold_addr;
    if (!rst_n) begin
      rd_addr = '0;
    end else if (grant0) begin
      rd_addr = bus.addr0;
    end else if (grant1) begin
      rd_addr = bus.addr1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      tag_valid <= 1'b0;
      tag_idx   <= 1'b0;
      hold_addr <= '0;
    end else begin
      tag_valid <= grant_any;
      tag_idx   <= grant1;
      if (grant_any) begin
        last      <= grant1;
        hold_addr <= rd_addr;
      end
    end
  end

  // ROM data arrives the cycle after the grant, alongside the tag that names its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (tag_valid) begin
      if (tag_idx) begin
        rdata1_q <= bus.rom_rd_data;
      end else begin
        rdata0_q <= bus.rom_rd_data;
      end
    end
  end

  assign bus.ack0        = grant0;
  assign bus.ack1        = grant1;
  assign bus.rom_rd_addr = rd_addr;
  assign bus.rvalid0     = tag_valid & ~tag_idx;
  assign bus.rvalid1     = tag_valid &  tag_idx;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// tb/tb_char_rom_arbiter.sv - directed self-checking bench for char_rom_arbiter
// ROM content is addr[7:0] ^ 0x5A ^ addr[11:8]; expected bytes below are worked out by hand from that rule.
module tb_char_rom_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  char_rom_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus();

  char_rom_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [11:0] a);
    return a[7:0] ^ 8'h5A ^ {4'h0, a[11:8]};
  endfunction

  always @(posedge clk) bus.rom_rd_data <= rom_val(bus.rom_rd_addr);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.addr0 = 12'h123; bus.addr1 = 12'h456;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b expected 0", bus.ack0); end
    checks++; if (bus.ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b expected 0", bus.ack1); end
    checks++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", bus.rvalid0, bus.rvalid1); end
    checks++; if (bus.rdata0 !== 8'h00) begin errors++; $display("FAIL reset_rdata0: got %h expected 00", bus.rdata0); end
    checks++; if (bus.rdata1 !== 8'h00) begin errors++; $display("FAIL reset_rdata1: got %h expected 00", bus.rdata1); end
    checks++; if (bus.rom_rd_addr !== 12'h000) begin errors++; $display("FAIL reset_rom_addr: got %h expected 000", bus.rom_rd_addr); end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1} !== 4'b0000) begin
        errors++; $display("FAIL idle_after_reset cycle %0d: got ack/rvalid %b expected 0000", i, {bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1});
      end
    end
  endtask

  task automatic test_single_read();
    next_cycle();
    bus.req0 = 1'b1; bus.addr0 = 12'h041;
    @(negedge clk);
    checks++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin errors++; $display("FAIL single_ack: got %b%b expected 10", bus.ack0, bus.ack1); end
    checks++; if (bus.rom_rd_addr !== 12'h041) begin errors++; $display("FAIL single_rom_addr: got %h expected 041", bus.rom_rd_addr); end
    checks++; if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL single_early_rvalid: got %b expected 0", bus.rvalid0); end
    next_cycle();
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++; if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0) begin errors++; $display("FAIL single_rvalid: got %b%b expected 10", bus.rvalid0, bus.rvalid1); end
    checks++; if (bus.rom_rd_addr !== 12'h041) begin errors++; $display("FAIL single_addr_hold: got %h expected 041", bus.rom_rd_addr); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL single_rvalid_pulse: got %b expected 0", bus.rvalid0); end
    checks++; if (bus.rdata0 !== 8'h1B) begin errors++; $display("FAIL single_rdata0: got %h expected 1B", bus.rdata0); end
  endtask

  task automatic test_contention();
    logic [5:0]  e_a0;
    logic [5:0]  e_a1;
    logic [5:0]  e_rv0;
    logic [5:0]  e_rv1;
    logic [11:0] e_addr;
    e_a0 = 6'b000101; e_a1 = 6'b001010;
    e_rv0 = 6'b001010; e_rv1 = 6'b010100;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    bus.addr0 = 12'h100; bus.addr1 = 12'h205;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      bus.req0 = (i < 4); bus.req1 = (i < 4);
      @(negedge clk);
      e_addr = e_a0[i] ? 12'h100 : 12'h205;
      checks++; if (bus.ack0 !== e_a0[i] || bus.ack1 !== e_a1[i]) begin errors++; $display("FAIL contention_ack cycle %0d: got %b%b expected %b%b", i, bus.ack0, bus.ack1, e_a0[i], e_a1[i]); end
      checks++; if (bus.rvalid0 !== e_rv0[i] || bus.rvalid1 !== e_rv1[i]) begin errors++; $display("FAIL contention_rvalid cycle %0d: got %b%b expected %b%b", i, bus.rvalid0, bus.rvalid1, e_rv0[i], e_rv1[i]); end
      checks++; if (bus.rom_rd_addr !== e_addr) begin errors++; $display("FAIL contention_rom_addr cycle %0d: got %h expected %h", i, bus.rom_rd_addr, e_addr); end
    end
    checks++; if (bus.rdata0 !== 8'h5B) begin errors++; $display("FAIL contention_rdata0: got %h expected 5B", bus.rdata0); end
    checks++; if (bus.rdata1 !== 8'h5D) begin errors++; $display("FAIL contention_rdata1: got %h expected 5D", bus.rdata1); end
  endtask

  task automatic test_fairness();
    logic pa0;
    logic pa1;
    logic ea0;
    logic ea1;
    pa0 = 1'b0; pa1 = 1'b0;
    bus.addr0 = 12'h033; bus.addr1 = 12'h144;
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      bus.req1 = (i < 12);
      bus.req0 = (i < 12) && (i % 3 == 0);
      ea0 = (i < 12) && (i % 3 == 0);
      ea1 = (i < 12) && (i % 3 != 0);
      @(negedge clk);
      checks++; if (bus.ack0 !== ea0 || bus.ack1 !== ea1) begin errors++; $display("FAIL fairness_ack cycle %0d: got %b%b expected %b%b", i, bus.ack0, bus.ack1, ea0, ea1); end
      checks++; if (bus.rvalid0 !== pa0 || bus.rvalid1 !== pa1) begin errors++; $display("FAIL fairness_rvalid cycle %0d: got %b%b expected %b%b", i, bus.rvalid0, bus.rvalid1, pa0, pa1); end
      pa0 = ea0; pa1 = ea1;
    end
    checks++; if (bus.rdata0 !== 8'h69) begin errors++; $display("FAIL fairness_rdata0: got %h expected 69", bus.rdata0); end
    checks++; if (bus.rdata1 !== 8'h1F) begin errors++; $display("FAIL fairness_rdata1: got %h expected 1F", bus.rdata1); end
  endtask

  task automatic test_hold();
    next_cycle();
    bus.req1 = 1'b1; bus.addr1 = 12'h0F0;
    @(negedge clk);
    checks++; if (bus.ack1 !== 1'b1) begin errors++; $display("FAIL hold_ack1: got %b expected 1", bus.ack1); end
    next_cycle();
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++; if (bus.rvalid1 !== 1'b1) begin errors++; $display("FAIL hold_rvalid1: got %b expected 1", bus.rvalid1); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rdata1 !== 8'hAA) begin errors++; $display("FAIL hold_rdata1_load: got %h expected AA", bus.rdata1); end
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      bus.req0 = 1'b1; bus.addr0 = 12'h300 + 12'(i * 8);
      @(negedge clk);
      checks++; if (bus.ack0 !== 1'b1 || bus.rvalid1 !== 1'b0) begin errors++; $display("FAIL hold_traffic cycle %0d: got ack0 %b rvalid1 %b expected 1 0", i, bus.ack0, bus.rvalid1); end
      checks++; if (bus.rdata1 !== 8'hAA) begin errors++; $display("FAIL hold_rdata1 cycle %0d: got %h expected AA", i, bus.rdata1); end
    end
    next_cycle();
    bus.req0 = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rdata0 !== 8'hC1) begin errors++; $display("FAIL hold_rdata0_last: got %h expected C1", bus.rdata0); end
  endtask

  task automatic test_reset_midflight();
    next_cycle();
    bus.req1 = 1'b1; bus.addr1 = 12'h041;
    @(negedge clk);
    checks++; if (bus.ack1 !== 1'b1) begin errors++; $display("FAIL midflight_ack1: got %b expected 1", bus.ack1); end
    next_cycle();
    bus.req1 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin errors++; $display("FAIL midflight_rvalid_in_reset: got %b%b expected 00", bus.rvalid0, bus.rvalid1); end
    checks++; if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin errors++; $display("FAIL midflight_rdata_cleared: got %h %h expected 00 00", bus.rdata0, bus.rdata1); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin errors++; $display("FAIL midflight_rvalid_after: got %b%b expected 00", bus.rvalid0, bus.rvalid1); end
    next_cycle();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.addr0 = 12'h205; bus.addr1 = 12'h100;
    @(negedge clk);
    checks++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin errors++; $display("FAIL midflight_first_grant: got %b%b expected 10", bus.ack0, bus.ack1); end
    checks++; if (bus.rom_rd_addr !== 12'h205) begin errors++; $display("FAIL midflight_rom_addr: got %h expected 205", bus.rom_rd_addr); end
    next_cycle();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    checks++; if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0) begin errors++; $display("FAIL midflight_return: got %b%b expected 10", bus.rvalid0, bus.rvalid1); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rdata0 !== 8'h5D || bus.rdata1 !== 8'h00) begin errors++; $display("FAIL midflight_rdata: got %h %h expected 5D 00", bus.rdata0, bus.rdata1); end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_hold();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
